// File: rtl/seq_pkg.sv
// Shared state encodings and timing defaults for the multicycle sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6,
        StError  = 3'd7
    } state_e;

    localparam int unsigned MemTimeoutDefault = 16;
    // Wide enough for the largest allowed MEM_TIMEOUT (255).
    localparam int unsigned WaitW = 8;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts unacknowledged request cycles and flags the cycle on which the wait limit is reached.
module mem_wait_timer
    import seq_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MemTimeoutDefault
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic ack,
    output logic expire
);

    logic [WaitW-1:0] cnt_q, cnt_d;

    // Idle between requests keeps the counter at zero, so every FETCH/MEM entry starts clean.
    always_comb begin
        cnt_d = cnt_q;
        if (!req || ack) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + WaitW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // An ack on the final allowed cycle wins over the timeout.
    assign expire = req && !ack && (cnt_q == WaitW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with shared request timeout.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MemTimeoutDefault,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dec_mem_read,
    input  logic             dec_mem_write,
    input  logic             dec_reg_write,
    input  logic             dec_halt,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             ir_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             req_active;
    logic             ack_sel;
    logic             expire;

    assign req_active = (state_q == StFetch) || (state_q == StMem);
    assign ack_sel    = (state_q == StFetch) ? imem_ack : dmem_ack;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_active),
        .ack   (ack_sel),
        .expire(expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StWb) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                imem_req = 1'b1;
                ir_we    = imem_ack;
                if (imem_ack)    state_d = StDecode;
                else if (expire) state_d = StError;
            end
            StDecode: begin
                state_d = dec_halt ? StHalt : StExec;
            end
            StExec: begin
                if (dec_mem_read && dec_mem_write)      state_d = StError;
                else if (dec_mem_read || dec_mem_write) state_d = StMem;
                else                                    state_d = StWb;
            end
            StMem: begin
                dmem_req = 1'b1;
                dmem_we  = dec_mem_write;
                if (dmem_ack)    state_d = StWb;
                else if (expire) state_d = StError;
            end
            StWb: begin
                pc_we   = 1'b1;
                rf_we   = dec_reg_write;
                state_d = StFetch;
            end
            StHalt:  state_d = StHalt;
            StError: state_d = StError;
            default: state_d = StError;
        endcase
    end

    assign busy    = !((state_q == StIdle) || (state_q == StHalt) || (state_q == StError));
    assign halted  = (state_q == StHalt);
    assign err     = (state_q == StError);
    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized self-checking bench: per-instruction expected timelines built from cycle-count rules.
module tb_multicycle_sequencer;

    localparam int T  = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          dec_mem_read = 1'b0, dec_mem_write = 1'b0;
    logic          dec_reg_write = 1'b0, dec_halt = 1'b0;
    logic          imem_ack = 1'b0, dmem_ack = 1'b0;
    logic          imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we;
    logic          busy, halted, err;
    logic [2:0]    state;
    logic [CW-1:0] retired;

    multicycle_sequencer #(
        .MEM_TIMEOUT(T),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .dec_mem_read (dec_mem_read),
        .dec_mem_write(dec_mem_write),
        .dec_reg_write(dec_reg_write),
        .dec_halt     (dec_halt),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ack     (dmem_ack),
        .ir_we        (ir_we),
        .rf_we        (rf_we),
        .pc_we        (pc_we),
        .busy         (busy),
        .halted       (halted),
        .err          (err),
        .state        (state),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    // One expected cycle: state, acks to drive, strobes {imem_req,ir_we,dmem_req,dmem_we,rf_we,pc_we}.
    typedef struct packed {
        logic [2:0] st;
        logic       imem_ack;
        logic       dmem_ack;
        logic [5:0] strb;
        logic       dec_ok;
    } ent_t;

    ent_t tl[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   model_ret = 0;
    bit   idle_m = 1'b1;
    int   outcome;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand();
        start         = 1'($urandom);
        imem_ack      = 1'($urandom);
        dmem_ack      = 1'($urandom);
        dec_mem_read  = 1'($urandom);
        dec_mem_write = 1'($urandom);
        dec_reg_write = 1'($urandom);
        dec_halt      = 1'($urandom);
    endtask

    task automatic check_outs(input string ctx, input logic [2:0] st, input logic [5:0] strb,
                              input logic [2:0] flags);
        check_eq({ctx, "_state"}, 32'(state), 32'(st));
        check_eq({ctx, "_strobes"},
                 32'({imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we}), 32'(strb));
        check_eq({ctx, "_flags"}, 32'({busy, halted, err}), 32'(flags));
        check_eq({ctx, "_retired"}, 32'(retired), 32'(model_ret));
    endtask

    function automatic ent_t mk(input logic [2:0] st, input logic [5:0] strb, input logic ok);
        ent_t e;
        e        = '0;
        e.st     = st;
        e.strb   = strb;
        e.dec_ok = ok;
        return e;
    endfunction

    // Expected timeline for one instruction; outcome 0 = retired, 1 = halt, 2 = error.
    task automatic build(input int kind, input int di, input int dd, input logic rw);
        ent_t e;
        logic mw;
        tl.delete();
        mw = (kind == 2) || (kind == 4);
        for (int j = 0; j < T && j <= di; j++) begin
            e = mk(3'd1, {1'b1, (j == di), 4'b0}, 1'b0);
            e.imem_ack = (j == di);
            tl.push_back(e);
        end
        if (di >= T) begin outcome = 2; return; end
        tl.push_back(mk(3'd2, 6'b0, 1'b1));
        if (kind == 3) begin outcome = 1; return; end
        tl.push_back(mk(3'd3, 6'b0, 1'b1));
        if (kind == 4) begin outcome = 2; return; end
        if (kind == 1 || kind == 2) begin
            for (int j = 0; j < T && j <= dd; j++) begin
                e = mk(3'd4, {2'b0, 1'b1, mw, 2'b0}, 1'b1);
                e.dmem_ack = (j == dd);
                tl.push_back(e);
            end
            if (dd >= T) begin outcome = 2; return; end
        end
        tl.push_back(mk(3'd5, {4'b0, rw, 1'b1}, 1'b1));
        outcome = 0;
    endtask

    task automatic reset_check();
        step();
        rst_n = 1'b1;
        drive_rand();
        start = 1'b0;
        model_ret = 0;
        idle_m = 1'b1;
        #1;
        check_outs("reset", 3'd0, 6'b0, 3'b000);
    endtask

    task automatic reset_dut();
        step();
        drive_rand();
        start = 1'b1;
        rst_n = 1'b0;
        reset_check();
    endtask

    task automatic run_instr(input int kind, input int di, input int dd, input logic rw,
                             input bit abort_mem);
        int   mem_n;
        ent_t e;
        mem_n = 0;
        if (idle_m) begin
            step();
            rst_n = 1'b1;
            drive_rand();
            start = 1'b1;
            #1;
            check_outs("idle", 3'd0, 6'b0, 3'b000);
            idle_m = 1'b0;
        end
        build(kind, di, dd, rw);
        for (int i = 0; i < tl.size(); i++) begin
            e = tl[i];
            step();
            rst_n = 1'b1;
            drive_rand();
            if (e.dec_ok) begin
                dec_mem_read  = (kind == 1) || (kind == 4);
                dec_mem_write = (kind == 2) || (kind == 4);
                dec_halt      = (kind == 3);
                dec_reg_write = rw;
            end
            if (e.st == 3'd1) imem_ack = e.imem_ack;
            if (e.st == 3'd4) begin
                dmem_ack = e.dmem_ack;
                mem_n++;
                if (abort_mem && mem_n == 2) rst_n = 1'b0;
            end
            #1;
            check_outs("run", e.st, e.strb, 3'b100);
            if (!rst_n) begin
                reset_check();
                return;
            end
            if (e.st == 3'd5) model_ret = (model_ret + 1) % (1 << CW);
        end
        if (outcome != 0) begin
            for (int k = 0; k < 3; k++) begin
                step();
                drive_rand();
                start = 1'b1;
                #1;
                if (outcome == 1) check_outs("halt", 3'd6, 6'b0, 3'b010);
                else              check_outs("error", 3'd7, 6'b0, 3'b001);
            end
            reset_dut();
        end
    endtask

    function automatic int rand_delay();
        return ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4))
                                          : int'($urandom_range(13, 17));
    endfunction

    initial begin
        int r, kind;
        reset_dut();
        // Directed cases first.
        run_instr(0, 0, 0, 1'b1, 1'b0);    // ALU, zero-wait
        run_instr(1, 3, 2, 1'b1, 1'b0);    // load with waits
        run_instr(2, 0, 0, 1'b0, 1'b0);    // store
        run_instr(0, T, 0, 1'b1, 1'b0);    // fetch timeout
        run_instr(0, T - 1, 0, 1'b1, 1'b0); // ack on last allowed fetch cycle
        run_instr(1, 0, T, 1'b1, 1'b0);    // mem timeout
        run_instr(2, 1, T - 1, 1'b0, 1'b0); // ack on last allowed mem cycle
        run_instr(3, 2, 0, 1'b0, 1'b0);    // halt
        run_instr(4, 0, 0, 1'b1, 1'b0);    // load+store conflict
        run_instr(1, 0, 6, 1'b1, 1'b1);    // reset mid-MEM
        // Randomized program.
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 99);
            kind = (r < 40) ? 0 : (r < 65) ? 1 : (r < 85) ? 2 : (r < 93) ? 3 : 4;
            run_instr(kind, rand_delay(), rand_delay(), 1'($urandom), 1'b0);
        end
        // Counter wrap: retire 2^CW + 1 instructions from reset.
        reset_dut();
        for (int n = 0; n <= (1 << CW); n++) begin
            run_instr(0, 0, 0, 1'($urandom), 1'b0);
        end
        run_instr(1, 1, 1, 1'b1, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: maximum number of request cycles without an ack before an error (range 2..255).
REQ-002 SHALL have parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 SHALL have these ports, in this order:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin execution; sampled only in IDLE.
- dec_mem_read  in  1  decoded load flag.
- dec_mem_write  in  1  decoded store flag.
- dec_reg_write  in  1  decoded register-file write flag.
- dec_halt  in  1  decoded halt/illegal-opcode flag.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch data valid.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write qualifier.
- dmem_ack  in  1  data access complete.
- ir_we  out  1  instruction register load strobe.
- rf_we  out  1  register-file write strobe.
- pc_we  out  1  PC update strobe.
- busy  out  1  high in any state other than IDLE, HALT or ERROR.
- halted  out  1  high in HALT.
- err  out  1  high in ERROR.
- state  out  3  current state encoding.
- retired  out  CNT_W  count of completed instructions.
REQ-004 SHALL treat all dec_* inputs as stable from DECODE through WB, because the instruction register is held over that span.

Function
REQ-005 SHALL use these state encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERROR=7.
REQ-006 IDLE: when start=1, SHALL move to FETCH on the next cycle; otherwise SHALL remain in IDLE.
REQ-007 FETCH: SHALL assert imem_req every cycle of the state; on the cycle imem_ack=1, SHALL pulse ir_we for that cycle and move to DECODE.
REQ-008 DECODE: SHALL last one cycle; if dec_halt=1, SHALL move to HALT, otherwise to EXEC.
REQ-009 EXEC: SHALL last one cycle.
- dec_mem_read and dec_mem_write both 1: move to ERROR.
- Exactly one of them 1: move to MEM.
- Neither: move to WB.
REQ-010 MEM: SHALL assert dmem_req, with dmem_we equal to dec_mem_write, until dmem_ack=1, then move to WB.
REQ-011 WB: SHALL last one cycle, with pc_we=1 and rf_we=dec_reg_write; SHALL increment retired by 1 (wrapping from all-ones to 0) and move to FETCH.
REQ-012 HALT and ERROR SHALL be absorbing states, left only by reset.
REQ-013 ir_we, rf_we, pc_we, imem_req, dmem_req and dmem_we SHALL be 0 in every state and cycle not named above.
REQ-014 Latency with zero-wait acks SHALL be:
- 4 cycles per non-memory instruction (FETCH, DECODE, EXEC, WB).
- 5 cycles per load or store.
REQ-015 Timeout behaviour:
- A wait counter SHALL clear on entry to FETCH or MEM and increment on each request cycle with ack=0.
- If ack=0 on the MEM_TIMEOUT-th request cycle, SHALL move to ERROR.
- An ack on that same cycle SHALL win; the transition proceeds normally.
REQ-016 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.
REQ-017 start outside IDLE SHALL be ignored.
REQ-018 An ack in the first request cycle SHALL complete that cycle (no minimum wait).

Reset
REQ-019 When rst_n=0 at a clock edge, the next state SHALL be IDLE.
REQ-020 Reset values SHALL be: retired=0, wait counter=0, all strobes and requests 0, busy=0, halted=0, err=0, state=0.
REQ-021 Reset in the middle of FETCH or MEM SHALL drop the request on the next cycle, without completing the access or pulsing any strobe.

Structure
REQ-022 State encodings and the MEM_TIMEOUT default SHALL live in shared package seq_pkg.
REQ-023 The wait counter and timeout compare SHALL be one sub-module, mem_wait_timer, instantiated once and shared by FETCH and MEM.
REQ-024 Outputs SHALL be decoded from the registered state plus dec_* inputs only, with no combinational path from the ack inputs to the strobes other than ir_we.

Verification
REQ-025 Reset then start=1 with an ALU instruction and immediate imem_ack -> states 1,2,3,5; pc_we and rf_we high in cycle 4; retired=1.
REQ-026 Load with imem_ack delayed 3 cycles and dmem_ack delayed 2 cycles -> FETCH lasts 4 cycles, MEM lasts 3 cycles, dmem_we=0, rf_we=1 in WB.
REQ-027 Store (dec_mem_write=1, dec_reg_write=0) -> dmem_we=1 throughout MEM; rf_we=0 and pc_we=1 in WB.
REQ-028 With MEM_TIMEOUT=16:
- imem_ack never asserted -> err=1 after exactly 16 FETCH cycles.
- imem_ack on the 16th FETCH cycle -> DECODE, no error.
REQ-029 dec_halt=1 -> halted=1 and busy=0; start pulses are ignored; rst_n=0 -> IDLE.
REQ-030 Run 65,536 instructions -> retired wraps to 0; rst_n=0 during MEM -> dmem_req=0 and state=0 on the next cycle.
